// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready output stage.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } state_t;

   state_t          state, state_nxt;
   logic            rx_meta, rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            bit_tick;
   logic            stop_sample, stop_bad, byte_done;
`ifdef UART_RX_PARITY_EN
   logic            par_bit, par_bad;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign bit_tick = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!rx_s) state_nxt = START;
         START:     if (bit_tick) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:      if (bit_tick && bit_idx == 3'd7) state_nxt = PARITY;
         PARITY:    if (bit_tick) state_nxt = STOP;
`else
         DATA:      if (bit_tick && bit_idx == 3'd7) state_nxt = STOP;
`endif
         STOP:      if (bit_tick) state_nxt = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rx_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      stop_sample = (state == STOP) && bit_tick;
      stop_bad    = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
      par_bad     = stop_sample && (^{shreg, par_bit});
      byte_done   = stop_sample && rx_s && !(^{shreg, par_bit});
`else
      byte_done   = stop_sample && rx_s;
`endif
   end

   // Counter reloads a full bit on every sample, so samples stay mid-bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               bit_idx <= '0;
               if (!rx_s) cnt <= HALF_BIT;
            end
            START: cnt <= bit_tick ? FULL_BIT : cnt - CW'(1);
            DATA: begin
               cnt <= bit_tick ? FULL_BIT : cnt - CW'(1);
               if (bit_tick) begin
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               cnt <= bit_tick ? FULL_BIT : cnt - CW'(1);
               if (bit_tick) par_bit <= rx_s;
            end
`endif
            STOP:    cnt <= bit_tick ? '0 : cnt - CW'(1);
            default: cnt <= '0;
         endcase
      end
   end

   // A completion on a transfer cycle reloads; otherwise a pending byte wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= stop_bad;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= par_bad;
`endif
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         if (byte_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx  input  1  serial line (monitored rx tap), idle high, asynchronous to clk.
REQ-005 SHALL have port rx_data  output  8  received byte.
REQ-006 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decoding uses the synchronized value rx_s.
REQ-012 SHALL frame 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE (plus PARITY under REQ-027).
REQ-014 IDLE->START when rx_s is 0; the bit counter loads CLKS_PER_BIT/2 (integer division).
REQ-015 At mid-start sample: rx_s 0 -> DATA; rx_s 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA samples every CLKS_PER_BIT cycles after mid-start, shifting 8 bits; a 3-bit index counts 0..7 then -> STOP.
REQ-017 STOP sample rx_s 1 -> byte complete, -> IDLE; rx_s 0 -> frame_err pulse, byte discarded, -> WAIT_IDLE.
REQ-018 WAIT_IDLE -> IDLE on first cycle rx_s is 1 (break or line-low handling); no START while rx_s is 0.
REQ-019 On byte completion, rx_data and rx_valid update on the clock edge after the stop sample.
REQ-020 Handshake: transfer occurs on a cycle with rx_valid and rx_ready both high; rx_valid falls next cycle unless REQ-022 applies.
REQ-021 While rx_valid is high and no transfer occurs, rx_data SHALL hold stable.
REQ-022 A completion on a transfer cycle loads the new byte, rx_valid stays high, no overrun.
REQ-023 A completion while rx_valid is high and rx_ready is low: the new byte is dropped, the old byte is kept, overrun pulses 1 cycle.
REQ-024 Timing counter width SHALL be $clog2(CLKS_PER_BIT+1); counting never wraps mid-bit.

Reset
REQ-025 On rst: state IDLE, synchronizer flops 1, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, busy 0, counters 0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no flags; after release, a new frame is only detected on a fresh falling edge of rx_s.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined: a PARITY state between DATA and STOP samples one even-parity bit; on mismatch, parity_err (output, 1 bit, reset 0) pulses 1 cycle after the stop sample and the byte is discarded (rx_valid not asserted); the frame is 8E1.
REQ-028 Without UART_RX_PARITY_EN: no PARITY state, no parity_err port; the frame is 8N1.

Verification (CLKS_PER_BIT=8)
REQ-029 Send 0xA5 8N1 with rx_ready=1 -> rx_valid high 1 cycle with rx_data=0xA5; frame_err=0.
REQ-030 Low pulse on rx of 3 cycles -> returns to IDLE; no rx_valid, no frame_err.
REQ-031 Send 0x3C with stop bit 0, then hold rx low 40 cycles -> frame_err 1 pulse, rx_valid stays 0, busy stays high until rx returns to 1.
REQ-032 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun 1 pulse at 0x22 completion; raising rx_ready transfers 0x11.
REQ-033 Assert rst at DATA bit 4 of 0xFF -> all outputs at reset values; the next frame, 0x5A, is received correctly.
REQ-034 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; with parity bit 1 -> rx_data=0x07.
